// File: rtl/rx_mac_interface.sv
// MAC RX client to frame-memory writer: stores header + payload qwords per frame,
// publishes the write pointer only after a good frame's header is in memory.
module rx_mac_interface #(
    parameter int unsigned AW = 9
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [63:0]   rx_data,
    input  logic [7:0]    rx_data_valid,
    input  logic          rx_good_frame,
    input  logic          rx_bad_frame,
    output logic [AW-1:0] wr_addr,
    output logic [63:0]   wr_data,
    output logic          wr_en,
    output logic [AW:0]   commited_wr_addr,
    input  logic [AW:0]   commited_rd_addr,
    output logic [31:0]   frames_received,
    output logic [31:0]   frames_dropped
);

    typedef enum logic [1:0] {IDLE, RECV, COMMIT, DROP} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   sof_ptr_q, sof_ptr_d;
    logic [AW:0]   cur_ptr_q, cur_ptr_d;
    logic [AW:0]   pub_ptr_q, pub_ptr_d;
    logic          pub_pend_q, pub_pend_d;
    logic [31:0]   byte_cnt_q, byte_cnt_d;
    logic [31:0]   rcv_q, rcv_d;
    logic [31:0]   drp_q, drp_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [63:0]   wr_data_q, wr_data_d;
    logic [AW:0]   commit_q, commit_d;

    logic [AW:0]   first_ptr, used_first, used_cur;
    logic [3:0]    beat_n;
    logic [32:0]   byte_sum;
    logic          beat, frame_end, fit_first, fit_cur;

    function automatic logic [3:0] beat_bytes(input logic [7:0] v);
        beat_bytes = '0;
        for (int unsigned i = 0; i < 8; i++)
            if (v[i]) beat_bytes = 4'(i + 1);
    endfunction

    // A qword at pointer p is legal only while p - rd leaves the wrap bit clear.
    assign first_ptr  = wr_ptr_q + (AW+1)'(1);
    assign used_first = first_ptr - commited_rd_addr;
    assign used_cur   = cur_ptr_q - commited_rd_addr;
    assign fit_first  = ~used_first[AW];
    assign fit_cur    = ~used_cur[AW];
    assign beat       = |rx_data_valid;
    assign frame_end  = rx_good_frame | rx_bad_frame;
    assign beat_n     = beat_bytes(rx_data_valid);
    assign byte_sum   = {1'b0, byte_cnt_q} + 33'(beat_n);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        sof_ptr_d  = sof_ptr_q;
        cur_ptr_d  = cur_ptr_q;
        pub_ptr_d  = pub_ptr_q;
        pub_pend_d = 1'b0;
        byte_cnt_d = byte_cnt_q;
        rcv_d      = rcv_q;
        drp_d      = drp_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        commit_d   = commit_q;

        // Publish one cycle after the header write so the reader never sees it early.
        if (pub_pend_q) begin
            commit_d = pub_ptr_q;
            rcv_d    = rcv_q + 32'd1;
        end

        case (state_q)
            IDLE: begin
                if (beat) begin
                    sof_ptr_d  = wr_ptr_q;
                    cur_ptr_d  = wr_ptr_q + (AW+1)'(2);
                    byte_cnt_d = 32'(beat_n);
                    if (!fit_first) begin
                        if (frame_end) drp_d = drp_q + 32'd1;
                        else           state_d = DROP;
                    end else if (rx_bad_frame) begin
                        drp_d = drp_q + 32'd1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = first_ptr[AW-1:0];
                        wr_data_d = rx_data;
                        state_d   = rx_good_frame ? COMMIT : RECV;
                    end
                end
            end
            RECV: begin
                if (beat && !fit_cur) begin
                    if (frame_end) begin
                        drp_d   = drp_q + 32'd1;
                        state_d = IDLE;
                    end else begin
                        state_d = DROP;
                    end
                end else if (rx_bad_frame) begin
                    drp_d   = drp_q + 32'd1;
                    state_d = IDLE;
                end else begin
                    if (beat) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = cur_ptr_q[AW-1:0];
                        wr_data_d  = rx_data;
                        cur_ptr_d  = cur_ptr_q + (AW+1)'(1);
                        byte_cnt_d = byte_sum[32] ? '1 : byte_sum[31:0];
                    end
                    if (rx_good_frame) state_d = COMMIT;
                end
            end
            COMMIT: begin
                wr_en_d    = 1'b1;
                wr_addr_d  = sof_ptr_q[AW-1:0];
                wr_data_d  = {byte_cnt_q, 32'h0};
                wr_ptr_d   = cur_ptr_q;
                pub_ptr_d  = cur_ptr_q;
                pub_pend_d = 1'b1;
                state_d    = IDLE;
                if (beat) begin
                    if (frame_end) drp_d = drp_q + 32'd1;
                    else           state_d = DROP;
                end
            end
            DROP: begin
                if (frame_end) begin
                    drp_d   = drp_q + 32'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            sof_ptr_q  <= '0;
            cur_ptr_q  <= '0;
            pub_ptr_q  <= '0;
            pub_pend_q <= 1'b0;
            byte_cnt_q <= '0;
            rcv_q      <= '0;
            drp_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            commit_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            sof_ptr_q  <= sof_ptr_d;
            cur_ptr_q  <= cur_ptr_d;
            pub_ptr_q  <= pub_ptr_d;
            pub_pend_q <= pub_pend_d;
            byte_cnt_q <= byte_cnt_d;
            rcv_q      <= rcv_d;
            drp_q      <= drp_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            commit_q   <= commit_d;
        end
    end

    assign wr_en            = wr_en_q;
    assign wr_addr          = wr_addr_q;
    assign wr_data          = wr_data_q;
    assign commited_wr_addr = commit_q;
    assign frames_received  = rcv_q;
    assign frames_dropped   = drp_q;

endmodule

// File: tb/tb_rx_mac_interface.sv
// Scoreboard bench for rx_mac_interface: a frame-level model predicts every memory
// write and pointer publication; a negedge monitor pops and compares.
module tb_rx_mac_interface;

    localparam int unsigned AW = 9;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [63:0]   rx_data = '0;
    logic [7:0]    rx_data_valid = '0;
    logic          rx_good_frame = 1'b0;
    logic          rx_bad_frame = 1'b0;
    logic [AW-1:0] wr_addr;
    logic [63:0]   wr_data;
    logic          wr_en;
    logic [AW:0]   commited_wr_addr;
    logic [AW:0]   rd = '0;
    logic [31:0]   frames_received;
    logic [31:0]   frames_dropped;

    rx_mac_interface #(.AW(AW)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .rx_data          (rx_data),
        .rx_data_valid    (rx_data_valid),
        .rx_good_frame    (rx_good_frame),
        .rx_bad_frame     (rx_bad_frame),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .wr_en            (wr_en),
        .commited_wr_addr (commited_wr_addr),
        .commited_rd_addr (rd),
        .frames_received  (frames_received),
        .frames_dropped   (frames_dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [63:0]   data;
        bit            hdr;
    } wr_t;

    wr_t         wq[$];
    logic [AW:0] cq[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model: committed pointer and frame tallies.
    logic [AW:0] m_ptr = '0;
    int unsigned m_rcv = 0;
    int unsigned m_drp = 0;

    int          cyc = 0;
    int          hdr_cyc = -10;
    logic [AW:0] prev_commit = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (!reset_n) begin
            prev_commit = '0;
        end else begin
            if (wr_en) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data %0h expected no write", wr_addr, wr_data);
                end else begin
                    e = wq.pop_front();
                    check("wr_addr", 64'(wr_addr), 64'(e.addr));
                    check("wr_data", wr_data, e.data);
                    if (e.hdr) hdr_cyc = cyc;
                end
            end
            if (commited_wr_addr != prev_commit) begin
                if (cq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit: got %0d expected no change from %0d", commited_wr_addr, prev_commit);
                end else begin
                    check("commit_ptr", 64'(commited_wr_addr), 64'(cq.pop_front()));
                    check("commit_after_header", 64'(cyc), 64'(hdr_cyc + 1));
                end
                prev_commit = commited_wr_addr;
            end
        end
    end

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        rx_data       = '0;
        rx_data_valid = '0;
        rx_good_frame = 1'b0;
        rx_bad_frame  = 1'b0;
    endtask

    task automatic check_outputs_zero();
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", wr_data, 64'd0);
        check("rst_commit", 64'(commited_wr_addr), 64'd0);
        check("rst_frames_received", 64'(frames_received), 64'd0);
        check("rst_frames_dropped", 64'(frames_dropped), 64'd0);
    endtask

    task automatic model_reset();
        wq.delete();
        cq.delete();
        m_ptr = '0;
        m_rcv = 0;
        m_drp = 0;
        rd    = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        rx_data = '0;
        rx_data_valid = '0;
        rx_good_frame = 1'b0;
        rx_bad_frame = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero();
        reset_n = 1'b1;
        idle_cycle();
    endtask

    task automatic drain_and_count();
        for (int k = 0; k < 50 && (wq.size() != 0 || cq.size() != 0); k++) @(posedge clk);
        if (wq.size() != 0 || cq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d writes %0d commits pending expected 0", wq.size(), cq.size());
            wq.delete();
            cq.delete();
        end
        #1;
        check("frames_received", 64'(frames_received), 64'(m_rcv));
        check("frames_dropped", 64'(frames_dropped), 64'(m_drp));
    endtask

    // n beats, last beat carrying last_bytes bytes; end pulse either with the last beat or after it.
    task automatic send_frame(input int unsigned n, input int unsigned last_bytes, input bit good, input bit same_end);
        logic [AW:0]  a;
        logic [AW:0]  used;
        logic [63:0]  d;
        logic [31:0]  bytes;
        int unsigned  nb;
        bit           ok;
        bit           same;
        ok    = 1'b1;
        bytes = '0;
        same  = good && same_end && (n > 1);
        for (int unsigned i = 0; i < n; i++) begin
            if (i > 0 && $urandom_range(0, 5) == 0) idle_cycle();
            nb   = (i == n - 1) ? last_bytes : 8;
            d    = {$urandom, $urandom};
            a    = m_ptr + (AW+1)'(1 + i);
            used = a - rd;
            if (ok && used < (AW+1)'(1 << AW)) wq.push_back('{a[AW-1:0], d, 1'b0});
            else ok = 1'b0;
            bytes += 32'(nb);
            @(posedge clk);
            #1;
            rx_data       = d;
            rx_data_valid = 8'((1 << nb) - 1);
            rx_good_frame = same && (i == n - 1);
            rx_bad_frame  = 1'b0;
        end
        if (!same) begin
            @(posedge clk);
            #1;
            rx_data_valid = '0;
            rx_good_frame = good;
            rx_bad_frame  = !good;
        end
        if (good && ok) begin
            wq.push_back('{m_ptr[AW-1:0], {bytes, 32'h0}, 1'b1});
            m_ptr = m_ptr + (AW+1)'(n + 1);
            cq.push_back(m_ptr);
            m_rcv++;
        end else begin
            m_drp++;
        end
        repeat (3) idle_cycle();
        drain_and_count();
    endtask

    task automatic advance_rd();
        logic [AW:0] diff;
        diff = m_ptr - rd;
        rd   = rd + (AW+1)'($urandom_range(0, int'(diff)));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero();
        reset_n = 1'b1;
        idle_cycle();

        // End pulses with no open frame are ignored.
        @(posedge clk); #1; rx_good_frame = 1'b1;
        @(posedge clk); #1; rx_good_frame = 1'b0; rx_bad_frame = 1'b1;
        repeat (3) idle_cycle();
        drain_and_count();

        send_frame(8, 8, 1'b1, 1'b0);
        send_frame(8, 5, 1'b1, 1'b1);
        send_frame(4, 8, 1'b0, 1'b0);
        send_frame(3, 2, 1'b1, 1'b0);

        // Fill with the reader stalled until a frame overflows, then release space.
        do_reset();
        for (int f = 0; f < 70 && m_drp == 0; f++) send_frame(8, 8, 1'b1, 1'b0);
        rd = m_ptr;
        send_frame(8, 8, 1'b1, 1'b0);

        // Walk the pointer to 510 and straddle the end of memory.
        do_reset();
        for (int f = 0; f < 51; f++) begin
            send_frame(9, 8, 1'b1, 1'b0);
            rd = m_ptr;
        end
        send_frame(3, 8, 1'b1, 1'b0);

        for (int f = 0; f < 40; f++) begin
            advance_rd();
            send_frame($urandom_range(1, 12), $urandom_range(1, 8),
                       $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1);
        end

        // Asynchronous reset in the middle of beat 3.
        rd = m_ptr;
        wq.push_back('{7'(0) + m_ptr[AW-1:0] + AW'(1), 64'h1111_2222_3333_4444, 1'b0});
        @(posedge clk); #1; rx_data = 64'h1111_2222_3333_4444; rx_data_valid = 8'hFF;
        @(posedge clk); #1; rx_data = 64'h5555_6666_7777_8888;
        @(posedge clk); #1; rx_data = 64'h9999_AAAA_BBBB_CCCC;
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs_zero();
        rx_data_valid = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle_cycle();
        send_frame(2, 8, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
